// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped I-cache: hits answer 1 cycle after the request, misses refill a whole line by AXI INCR burst.
// Backpressure: fetch holds psel until pready; AR held until arready; R beats consumed only when rvalid.
module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_psel,
    input  logic [ADDR_WIDTH-1:0] in_paddr,
    output logic                  in_pready,
    output logic [DATA_WIDTH-1:0] in_prdata,
    input  logic                  fencei_i,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    output logic                  hit_o,
    output logic                  miss_o
);
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WOFF_BITS = OFFSET_BITS - 2;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << WOFF_BITS;

    typedef enum logic [1:0] {IDLE, AR, REFILL, RESP} state_t;
    state_t state, state_nxt;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [DATA_WIDTH-1:0] data_arr [LINES][WORDS];

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WOFF_BITS-1:0]  beat_cnt;
    logic [DATA_WIDTH-1:0] resp_word;
    logic                  err_flag;
    logic                  fence_pending;

    logic [INDEX_BITS-1:0] in_idx, req_idx;
    logic [TAG_BITS-1:0]   in_tag, req_tag;
    logic [WOFF_BITS-1:0]  in_woff, req_woff;

    assign in_idx   = in_paddr[OFFSET_BITS +: INDEX_BITS];
    assign in_tag   = in_paddr[ADDR_WIDTH-1 -: TAG_BITS];
    assign in_woff  = in_paddr[OFFSET_BITS-1:2];
    assign req_idx  = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_woff = req_addr[OFFSET_BITS-1:2];

    assign m_arlen   = 8'(WORDS - 1);
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{in_paddr[1:0], req_addr[1:0]};

    logic take, lookup_hit, ar_fire, r_fire, r_last_fire, beat_is_req, line_ok;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A fence in the same cycle as a lookup forces the miss path.
    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        lookup_hit  = 1'b0;
        ar_fire     = 1'b0;
        r_fire      = 1'b0;
        r_last_fire = 1'b0;
        case (state)
            IDLE: begin
                take       = in_psel && !in_pready;
                lookup_hit = valid[in_idx] && (tag_arr[in_idx] == in_tag) && !fencei_i;
                if (take && !lookup_hit) state_nxt = AR;
            end
            AR: begin
                ar_fire = m_arvalid && m_arready;
                if (ar_fire) state_nxt = REFILL;
            end
            REFILL: begin
                r_fire      = m_rvalid && m_rready;
                r_last_fire = r_fire && m_rlast;
                if (r_last_fire) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign beat_is_req = (beat_cnt == req_woff);
    assign line_ok     = !err_flag && (m_rresp == 2'b00) && !fence_pending && !fencei_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid         <= '0;
            in_pready     <= 1'b0;
            in_prdata     <= '0;
            hit_o         <= 1'b0;
            miss_o        <= 1'b0;
            m_arvalid     <= 1'b0;
            m_araddr      <= '0;
            m_rready      <= 1'b0;
            req_addr      <= '0;
            beat_cnt      <= '0;
            resp_word     <= '0;
            err_flag      <= 1'b0;
            fence_pending <= 1'b0;
        end else begin
            in_pready <= 1'b0;
            hit_o     <= 1'b0;
            miss_o    <= 1'b0;
            if (take && lookup_hit) begin
                in_pready <= 1'b1;
                in_prdata <= data_arr[in_idx][in_woff];
                hit_o     <= 1'b1;
            end
            if (take && !lookup_hit) begin
                req_addr  <= in_paddr;
                miss_o    <= 1'b1;
                m_arvalid <= 1'b1;
                m_araddr  <= {in_tag, in_idx, {OFFSET_BITS{1'b0}}};
            end
            if (ar_fire) begin
                m_arvalid <= 1'b0;
                m_rready  <= 1'b1;
                beat_cnt  <= '0;
                err_flag  <= 1'b0;
            end
            if (r_fire) begin
                beat_cnt <= beat_cnt + WOFF_BITS'(1);
                if (m_rresp != 2'b00) err_flag <= 1'b1;
                if (beat_is_req) resp_word <= m_rdata;
            end
            // The requested word may arrive on the last beat itself, so bypass resp_word then.
            if (r_last_fire) begin
                m_rready  <= 1'b0;
                in_pready <= 1'b1;
                in_prdata <= beat_is_req ? m_rdata : resp_word;
            end
            if (state == RESP) fence_pending <= 1'b0;
            if (fencei_i && (state == AR || state == REFILL)) fence_pending <= 1'b1;
            if (fencei_i)         valid          <= '0;
            else if (r_last_fire) valid[req_idx] <= line_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && r_fire)      data_arr[req_idx][beat_cnt] <= m_rdata;
        if (!reset && r_last_fire) tag_arr[req_idx]            <= req_tag;
    end
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed-vector bench for ysyx_23060025_icache with a small AXI read responder.
module tb_ysyx_23060025_icache;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_psel;
    logic [31:0] in_paddr;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        fencei_i;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        hit_o;
    logic        miss_o;

    ysyx_23060025_icache dut (
        .clock(clock), .reset(reset),
        .in_psel(in_psel), .in_paddr(in_paddr), .in_pready(in_pready), .in_prdata(in_prdata),
        .fencei_i(fencei_i),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .hit_o(hit_o), .miss_o(miss_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] paddr;
        int          ar_hold;
        bit          gap;
        int          err_beat;
        bit          fence_mid;
        bit          pre_fence;
        bit          fence_same;
        bit          exp_hit;
        logic [31:0] exp_data;
        logic [31:0] exp_araddr;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Backing memory: two recognisable lines, everything else derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int b);
        if (line == 32'h3000_0000)      return 32'hA0 + 32'(b);
        else if (line == 32'h3000_0100) return 32'hB0 + 32'(b);
        else                            return 32'hC000_0000 + line + 32'(b);
    endfunction

    task automatic run_req(input vec_t v, input int id);
        int cyc = 0, ar_cyc = 0, beat = 0, nar = 0, nhit = 0, nmiss = 0, lat = 0;
        bit rphase = 0, done = 0, ar_stable = 1, arf, rf, gap_tog = 0;
        logic [31:0] araddr0 = '0, got = '0;
        if (v.pre_fence) begin
            @(negedge clock); fencei_i = 1'b1;
            @(negedge clock); fencei_i = 1'b0;
        end
        @(negedge clock);
        in_psel  = 1'b1;
        in_paddr = v.paddr;
        fencei_i = v.fence_same;
        while (!done && cyc < 300) begin
            arf = m_arvalid && m_arready;
            rf  = m_rvalid && m_rready;
            @(negedge clock);
            cyc++;
            fencei_i = 1'b0;
            if (hit_o)  nhit++;
            if (miss_o) nmiss++;
            if (arf) begin nar++; rphase = 1; beat = 0; m_arready = 1'b0; end
            if (rf) begin
                beat++;
                if (v.fence_mid && beat == 1) fencei_i = 1'b1;
            end
            if (in_pready) begin done = 1; got = in_prdata; lat = cyc; in_psel = 1'b0; end
            if (m_arvalid) begin
                ar_cyc++;
                if (ar_cyc == 1) begin
                    araddr0 = m_araddr;
                    chk($sformatf("v%0d arlen", id), 32'(m_arlen), 32'd3);
                    chk($sformatf("v%0d arsize", id), 32'(m_arsize), 32'd2);
                    chk($sformatf("v%0d arburst", id), 32'(m_arburst), 32'd1);
                end else if (m_araddr !== araddr0) ar_stable = 0;
                m_arready = (ar_cyc > v.ar_hold);
            end
            if (rphase && beat < 4) begin
                gap_tog  = ~gap_tog;
                m_rvalid = !v.gap || gap_tog;
                m_rdata  = m_rvalid ? mem_word(araddr0, beat) : 32'hBAD0_BAD0;
                m_rlast  = m_rvalid && (beat == 3);
                m_rresp  = (m_rvalid && beat == v.err_beat) ? 2'b10 : 2'b00;
            end else begin
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                m_rresp  = 2'b00;
            end
        end
        in_psel   = 1'b0;
        fencei_i  = 1'b0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        chk($sformatf("v%0d answered", id), 32'(done), 32'd1);
        chk($sformatf("v%0d prdata", id), got, v.exp_data);
        chk($sformatf("v%0d hit_o", id), nhit, v.exp_hit ? 1 : 0);
        chk($sformatf("v%0d miss_o", id), nmiss, v.exp_hit ? 0 : 1);
        chk($sformatf("v%0d ar count", id), nar, v.exp_hit ? 0 : 1);
        if (v.exp_hit) chk($sformatf("v%0d hit latency", id), lat, 1);
        else begin
            chk($sformatf("v%0d araddr", id), araddr0, v.exp_araddr);
            chk($sformatf("v%0d araddr stable", id), 32'(ar_stable), 32'd1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " pready"}, 32'(in_pready), 0);
        chk({tag, " prdata"}, in_prdata, 0);
        chk({tag, " arvalid"}, 32'(m_arvalid), 0);
        chk({tag, " araddr"}, m_araddr, 0);
        chk({tag, " rready"}, 32'(m_rready), 0);
        chk({tag, " hit_o"}, 32'(hit_o), 0);
        chk({tag, " miss_o"}, 32'(miss_o), 0);
    endtask

    vec_t vecs[18];

    initial begin
        int cyc, npready;
        //            paddr          hold gap err fm pf fs hit data            araddr
        vecs[0]  = '{32'h3000_0008, 0, 0, -1, 0, 0, 0, 0, 32'h0000_00A2, 32'h3000_0000};
        vecs[1]  = '{32'h3000_000C, 0, 0, -1, 0, 0, 0, 1, 32'h0000_00A3, 32'h0};
        vecs[2]  = '{32'h3000_0000, 0, 0, -1, 0, 0, 0, 1, 32'h0000_00A0, 32'h0};
        vecs[3]  = '{32'h3000_0104, 0, 0, -1, 0, 0, 0, 0, 32'h0000_00B1, 32'h3000_0100};
        vecs[4]  = '{32'h3000_0000, 0, 0, -1, 0, 0, 0, 0, 32'h0000_00A0, 32'h3000_0000};
        vecs[5]  = '{32'h3000_0234, 5, 1, -1, 0, 0, 0, 0, 32'hF000_0231, 32'h3000_0230};
        vecs[6]  = '{32'h3000_0238, 0, 0, -1, 0, 0, 0, 1, 32'hF000_0232, 32'h0};
        vecs[7]  = '{32'h3000_0000, 0, 0, -1, 0, 1, 0, 0, 32'h0000_00A0, 32'h3000_0000};
        vecs[8]  = '{32'h3000_0108, 0, 0, -1, 1, 0, 0, 0, 32'h0000_00B2, 32'h3000_0100};
        vecs[9]  = '{32'h3000_0108, 0, 0, -1, 0, 0, 0, 0, 32'h0000_00B2, 32'h3000_0100};
        vecs[10] = '{32'h3000_010C, 0, 0, -1, 0, 0, 0, 1, 32'h0000_00B3, 32'h0};
        vecs[11] = '{32'h3000_0404, 0, 0,  1, 0, 0, 0, 0, 32'hF000_0401, 32'h3000_0400};
        vecs[12] = '{32'h3000_0404, 0, 0, -1, 0, 0, 0, 0, 32'hF000_0401, 32'h3000_0400};
        vecs[13] = '{32'h3000_0400, 0, 0, -1, 0, 0, 0, 1, 32'hF000_0400, 32'h0};
        vecs[14] = '{32'h3000_0400, 0, 0, -1, 0, 0, 1, 0, 32'hF000_0400, 32'h3000_0400};
        vecs[15] = '{32'h3000_0400, 0, 0, -1, 0, 0, 0, 0, 32'hF000_0400, 32'h3000_0400};
        vecs[16] = '{32'h3000_0504, 0, 0, -1, 0, 0, 0, 0, 32'hF000_0501, 32'h3000_0500};
        vecs[17] = '{32'h3000_0500, 0, 0, -1, 0, 0, 0, 1, 32'hF000_0500, 32'h0};

        reset = 1'b1; in_psel = 1'b0; in_paddr = '0; fencei_i = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
        repeat (3) @(negedge clock);
        chk_idle_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i <= 14; i++) run_req(vecs[i], i);

        // Reset in the middle of a refill: burst is abandoned, nothing is answered.
        @(negedge clock);
        in_psel = 1'b1; in_paddr = 32'h3000_0504;
        cyc = 0; npready = 0;
        while (!m_arvalid && cyc < 20) begin
            @(negedge clock); cyc++;
            if (in_pready) npready++;
        end
        chk("midrst arvalid", 32'(m_arvalid), 1);
        m_arready = 1'b1;
        @(negedge clock); m_arready = 1'b0;
        if (in_pready) npready++;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_0000; m_rresp = 2'b00; m_rlast = 1'b0;
        @(negedge clock); m_rdata = 32'hDEAD_0001;
        if (in_pready) npready++;
        @(negedge clock); m_rvalid = 1'b0; in_psel = 1'b0; reset = 1'b1;
        if (in_pready) npready++;
        @(negedge clock);
        chk_idle_outputs("midrst");
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (in_pready || m_arvalid) npready++;
        end
        chk("midrst no pready", npready, 0);

        for (int i = 15; i <= 17; i++) run_req(vecs[i], i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ysyx_23060025_icache.md
Name: ysyx_23060025_icache

Overview:
Direct-mapped instruction cache that answers the fetch stage's PSEL/PADDR → PREADY/PRDATA request port, the responder end of that interface.
- Hits return one cycle after the request is seen.
- Misses refill a full line over an AXI4 read-burst master port, then return the requested word.
- Sits between the fetch stage and the instruction-side memory interconnect.
- Supports whole-cache invalidation for fence.i.

Parameters:
ADDR_WIDTH, 32, fetch/AXI address width
DATA_WIDTH, 32, instruction word and AXI data width
INDEX_BITS, 4, log2 of line count (16 lines)
OFFSET_BITS, 4, log2 of line bytes (16 B = 4 words); TAG = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS

Ports:
clock  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_psel  in  1  fetch request; held high, with in_paddr stable, until the cycle in_pready=1
in_paddr  in  ADDR_WIDTH  fetch address, word aligned
in_pready  out  1  registered one-cycle pulse: in_prdata valid this cycle
in_prdata  out  DATA_WIDTH  instruction word
fencei_i  in  1  one-cycle pulse: invalidate all lines
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_araddr  out  ADDR_WIDTH  line-aligned refill address
m_arlen  out  8  constant 2^(OFFSET_BITS-2)-1 (3)
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready
m_rdata  in  DATA_WIDTH  AXI R data
m_rresp  in  2  AXI R response
m_rlast  in  1  AXI R last
hit_o  out  1  one-cycle pulse per hit, for performance counting
miss_o  out  1  one-cycle pulse per miss, for performance counting

Behaviour:
- Storage:
  - valid[2^INDEX_BITS] held in flops.
  - tag and data arrays are read combinationally.
  - Address fields: index = paddr[OFFSET_BITS+:INDEX_BITS]; word offset = paddr[OFFSET_BITS-1:2].
- Reset:
  - All valid bits cleared; state=IDLE.
  - in_pready, in_prdata, m_arvalid, m_rready, hit_o, miss_o all 0; m_araddr = 0.
  - Reset mid-refill abandons the burst: no line is validated and no pready is issued. The interconnect is reset by the same reset.
- No combinational path from in_psel to in_pready; in_psel may depend combinationally on in_pready.
- States: IDLE, AR, REFILL, RESP.
- IDLE:
  - Request is taken when in_psel=1 and in_pready=0.
  - Hit (valid[idx] and tag match): next cycle in_pready=1, in_prdata=word, hit_o=1. Stay in IDLE. Latency is 1 cycle.
  - Miss: latch paddr, miss_o=1 next cycle, go to AR.
- AR:
  - m_arvalid=1, m_araddr = {tag, idx, OFFSET_BITS'b0}.
  - On m_arvalid & m_arready, drop m_arvalid and go to REFILL.
  - m_arvalid/m_araddr are held stable until the handshake.
- REFILL:
  - m_rready=1.
  - Each m_rvalid beat writes data[idx][beat_cnt], and beat_cnt increments (2-bit wrap).
  - The beat whose beat_cnt equals the latched word offset is also captured into the response register.
  - An m_rresp != 0 on any beat sets err_flag.
  - On the m_rlast beat:
    - write the tag;
    - set valid[idx] only if err_flag=0 (including this beat) and no fence is pending;
    - go to RESP.
  - m_rlast arriving early ends the refill at that beat.
- RESP: in_pready=1 with the captured word for one cycle, then IDLE. On error, the received (possibly garbage) word is still returned and the line is left invalid.
- fencei_i:
  - In IDLE/RESP: clear all valid bits next cycle.
  - In AR/REFILL: clear all valid bits immediately and set fence_pending, so the refilling line is not validated. fence_pending clears on return to IDLE.
  - fencei_i and a request in the same IDLE cycle: fence wins; the request is treated as a miss.
- A new request is never accepted in the in_pready=1 cycle.
- At most one outstanding AR.

Test Plan:
- Cold miss: psel, paddr=0x3000_0008 → one AR (araddr 0x3000_0000, arlen 3, arsize 2, burst 1); beats 0xA0,0xA1,0xA2,0xA3 with rlast on the 4th → one pready pulse with prdata=0xA2, miss_o pulsed once, valid[0] set.
- Hit after fill: paddr=0x3000_000C → pready exactly one cycle after psel, prdata=0xA3, hit_o=1, no AR.
- Conflict: fill 0x3000_0000, then request 0x3000_0100 (same index, new tag) → refill from 0x3000_0100; re-reading 0x3000_0000 misses again.
- Backpressure: hold arready=0 for 5 cycles, then insert rvalid gaps between beats → araddr stable until handshake, beats captured only when rvalid=1, correct word returned.
- Fence: pulse fencei_i in IDLE → next access to 0x3000_0000 misses. Pulse fencei_i mid-REFILL → request still answered, line not validated, re-access misses.
- Error/reset: rresp=2'b10 on beat 1 → pready delivered, line invalid, re-access misses. Assert reset during REFILL → all outputs 0, no pready, later request to the same line misses.
